// File: rtl/knapsack_engine_if.sv
// ---------------------------------------------------------------------------
// knapsack_engine_if
// Host-side bundle for the knapsack engine: item load stream (valid/ready),
// job start, and job status/results.
//   load_valid/load_ready/load_weight/load_value : item load handshake
//   start                                          : begin a job
//   busy/done                                      : job status
//   max_value/sel_mask/overflow                    : job results
// The slave modport is the engine side, the master modport the host side.
// ---------------------------------------------------------------------------
interface knapsack_engine_if #(
  parameter int ITEMS = 4,
  parameter int WW    = 10,
  parameter int VW    = 16
);
  logic             load_valid;
  logic             load_ready;
  logic [WW-1:0]    load_weight;
  logic [VW-1:0]    load_value;
  logic             start;
  logic             busy;
  logic             done;
  logic [VW-1:0]    max_value;
  logic [ITEMS-1:0] sel_mask;
  logic             overflow;

  modport slave (
    input  load_valid, load_weight, load_value, start,
    output load_ready, busy, done, max_value, sel_mask, overflow
  );

  modport master (
    output load_valid, load_weight, load_value, start,
    input  load_ready, busy, done, max_value, sel_mask, overflow
  );
endinterface

// File: rtl/knapsack_engine.sv
// ---------------------------------------------------------------------------
// knapsack_engine
// 0/1 knapsack solver with an in-place single-row DP and keep-bit traceback.
// Ports:
//   clk : clock, rising edge
//   res : asynchronous active-low reset
//   bus : knapsack_engine_if.slave (item load, start, busy/done, results)
// Flow: IDLE (load items) -> CLEAR (dp := 0) -> FILL (item x cell sweep)
//       -> TRACE (walk keep bits) -> DONE (publish results) -> IDLE.
// ---------------------------------------------------------------------------
module knapsack_engine #(
  parameter int ITEMS = 4,
  parameter int CAP   = 8,
  parameter int WW    = 10,
  parameter int VW    = 16
) (
  input  logic             clk,
  input  logic             res,
  knapsack_engine_if.slave bus
);

  localparam int CW  = (CAP > 0) ? $clog2(CAP + 1) : 1;
  localparam int IW  = $clog2(ITEMS + 1);
  localparam int IXW = (ITEMS > 1) ? $clog2(ITEMS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_TRACE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [IW-1:0]    r_n;        // items currently loaded
  logic [IW-1:0]    r_jn;       // item count latched for the running job
  logic [IW-1:0]    r_i;        // item cursor (FILL ascending, TRACE descending)
  logic [CW-1:0]    r_c;        // cell cursor for CLEAR/FILL
  logic [CW-1:0]    r_tc;       // remaining capacity during TRACE
  logic [ITEMS-1:0] r_mask;     // mask being built by TRACE
  logic             r_ovf_acc;  // saturation seen during this job

  logic             r_busy;
  logic             r_done;
  logic [VW-1:0]    r_max;
  logic [ITEMS-1:0] r_sel;
  logic             r_ovf;

  logic [WW-1:0]    r_w    [ITEMS];
  logic [VW-1:0]    r_v    [ITEMS];
  logic [VW-1:0]    r_dp   [CAP+1];
  logic [CAP:0]     r_keep [ITEMS];

  logic [IXW-1:0]   w_ix;
  logic [IXW-1:0]   w_nix;
  logic [CW-1:0]    w_wlo;
  logic [CW-1:0]    w_src;
  logic             w_fit;
  logic [VW:0]      w_sum;
  logic [VW-1:0]    w_s;
  logic             w_take;
  logic             w_c_last;
  logic             w_c_zero;
  logic             w_last_item;
  logic             w_load_ready;
  logic             w_load_fire;

  assign w_ix        = r_i[IXW-1:0];
  assign w_nix       = r_n[IXW-1:0];
  // Only used once the weight is known to fit, so the low bits are exact.
  assign w_wlo       = r_w[w_ix][CW-1:0];
  assign w_src       = r_c - w_wlo;
  // Compare in a common width; weights above CAP can never satisfy this.
  assign w_fit       = ({{CW{1'b0}}, r_w[w_ix]} <= {{WW{1'b0}}, r_c});
  assign w_sum       = {1'b0, r_dp[w_src]} + {1'b0, r_v[w_ix]};
  assign w_s         = w_sum[VW] ? {VW{1'b1}} : w_sum[VW-1:0];
  // Strict compare: ties leave the item out.
  assign w_take      = w_fit && (w_s > r_dp[r_c]);
  assign w_c_last    = (r_c == CW'(CAP));
  assign w_c_zero    = (r_c == {CW{1'b0}});
  assign w_last_item = (r_i == (r_jn - IW'(1)));
  assign w_load_ready = (r_state == S_IDLE) && (r_n < IW'(ITEMS)) && !bus.start;
  assign w_load_fire  = w_load_ready && bus.load_valid;

  assign bus.load_ready = w_load_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.max_value  = r_max;
  assign bus.sel_mask   = r_sel;
  assign bus.overflow   = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_CLEAR;
        else           w_next = S_IDLE;
      end
      S_CLEAR: begin
        // An empty job has nothing to fill or trace.
        if (w_c_last) w_next = (r_jn == IW'(0)) ? S_DONE : S_FILL;
        else          w_next = S_CLEAR;
      end
      S_FILL: begin
        if (w_c_zero && w_last_item) w_next = S_TRACE;
        else                         w_next = S_FILL;
      end
      S_TRACE: begin
        if (r_i == IW'(0)) w_next = S_DONE;
        else               w_next = S_TRACE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control counters, job flags and published results.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_n       <= '0;
      r_jn      <= '0;
      r_i       <= '0;
      r_c       <= '0;
      r_tc      <= '0;
      r_mask    <= '0;
      r_ovf_acc <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_max     <= '0;
      r_sel     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          // Start takes priority over a simultaneous load.
          if (bus.start) begin
            r_jn      <= r_n;
            r_ovf_acc <= 1'b0;
            r_c       <= '0;
            r_mask    <= '0;
          end else if (w_load_fire) begin
            r_n <= r_n + IW'(1);
          end
        end
        S_CLEAR: begin
          if (w_c_last) begin
            r_c  <= CW'(CAP);
            r_tc <= CW'(CAP);
            r_i  <= '0;
          end else begin
            r_c <= r_c + CW'(1);
          end
        end
        S_FILL: begin
          if (w_fit && w_sum[VW]) r_ovf_acc <= 1'b1;
          if (w_c_zero) begin
            r_c <= CW'(CAP);
            if (w_last_item) r_i <= r_jn - IW'(1);
            else             r_i <= r_i + IW'(1);
          end else begin
            r_c <= r_c - CW'(1);
          end
        end
        S_TRACE: begin
          if (r_keep[w_ix][r_tc]) begin
            r_mask[w_ix] <= 1'b1;
            r_tc         <= r_tc - w_wlo;
          end
          r_i <= r_i - IW'(1);
        end
        S_DONE: begin
          r_max <= r_dp[CW'(CAP)];
          r_sel <= r_mask;
          r_ovf <= r_ovf_acc;
          r_n   <= '0;
        end
        default: ;
      endcase
    end
  end

  // Item table, DP row and keep bits; contents are rebuilt every job.
  always_ff @(posedge clk) begin
    if (w_load_fire) begin
      r_w[w_nix] <= bus.load_weight;
      r_v[w_nix] <= bus.load_value;
    end
    if (r_state == S_CLEAR) begin
      r_dp[r_c] <= '0;
    end else if (r_state == S_FILL) begin
      if (w_take) r_dp[r_c] <= w_s;
      r_keep[w_ix][r_c] <= w_take;
    end
  end

endmodule
